// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

  // Controller state: normal flow, post-redirect fetch bubbles, data-memory freeze.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_t;

  // addi x0, x0, 0 -- what IF_ID / ID_EX load when flushed.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Architectural register index width.
  localparam int REG_IDX_W = 5;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the datapath and pipeline-register controls back to it.
interface pipeline_hazard_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic                 id_uses_rs1;
  logic                 id_uses_rs2;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 ex_mem_read;
  logic                 ex_branch_taken;
  logic [31:0]          ex_branch_target;
  logic                 dmem_busy;

  logic                 pc_write_en;
  logic                 pc_redirect;
  logic [31:0]          redirect_target;
  logic                 if_id_write_en;
  logic                 if_id_flush;
  logic                 id_ex_write_en;
  logic                 id_ex_flush;
  logic                 ex_mem_write_en;

  // Datapath side: presents hazard information, consumes controls.
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_branch_target, dmem_busy,
    input  pc_write_en, pc_redirect, redirect_target, if_id_write_en,
           if_id_flush, id_ex_write_en, id_ex_flush, ex_mem_write_en
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_branch_target, dmem_busy,
    output pc_write_en, pc_redirect, redirect_target, if_id_write_en,
           if_id_flush, id_ex_write_en, id_ex_flush, ex_mem_write_en
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  output logic                 load_use
);

  // x0 is never a real dependency, so a load into x0 cannot cause a stall.
  always_comb begin
    load_use = ex_mem_read && (ex_rd != '0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use stalls,
// branch redirects with fetch bubbles, data-memory freezes with a timeout.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255,
  parameter int CNT_W            = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  localparam logic [3:0]  BUBBLE_LOAD = 4'(REDIRECT_BUBBLES);
  localparam logic [15:0] WAIT_LIMIT  = 16'(MEM_TIMEOUT);

  ctrl_state_t state_reg, state_next;
  logic [3:0]  bubble_reg, bubble_next;
  logic [15:0] wait_reg, wait_next;
  logic        stall_inc, flush_inc, do_run, load_use;

  load_use_detect u_load_use (
    .id_rs1      (hz.id_rs1),
    .id_rs2      (hz.id_rs2),
    .id_uses_rs1 (hz.id_uses_rs1),
    .id_uses_rs2 (hz.id_uses_rs2),
    .ex_rd       (hz.ex_rd),
    .ex_mem_read (hz.ex_mem_read),
    .load_use    (load_use)
  );

  // Next-state and same-cycle control outputs; MEM_WAIT exit reuses the RUN rules.
  always_comb begin
    state_next  = state_reg;
    bubble_next = bubble_reg;
    wait_next   = wait_reg;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    do_run      = 1'b0;
    hz.pc_write_en     = 1'b1;
    hz.if_id_write_en  = 1'b1;
    hz.id_ex_write_en  = 1'b1;
    hz.ex_mem_write_en = 1'b1;
    hz.if_id_flush     = 1'b0;
    hz.id_ex_flush     = 1'b0;
    hz.pc_redirect     = 1'b0;
    hz.redirect_target = hz.ex_branch_target;

    case (state_reg)
      REDIRECT: begin
        hz.if_id_flush = 1'b1;
        if (hz.dmem_busy) begin
          // Freeze everything; the bubble count resumes once memory is ready.
          hz.pc_write_en     = 1'b0;
          hz.if_id_write_en  = 1'b0;
          hz.id_ex_write_en  = 1'b0;
          hz.ex_mem_write_en = 1'b0;
          stall_inc          = 1'b1;
        end else if (hz.ex_branch_taken) begin
          hz.pc_redirect = 1'b1;
          hz.id_ex_flush = 1'b1;
          flush_inc      = 1'b1;
          bubble_next    = BUBBLE_LOAD;
        end else if (bubble_reg <= 4'd1) begin
          state_next  = RUN;
          bubble_next = 4'd0;
        end else begin
          bubble_next = bubble_reg - 4'd1;
        end
      end
      MEM_WAIT: begin
        if (hz.dmem_busy) begin
          hz.pc_write_en     = 1'b0;
          hz.if_id_write_en  = 1'b0;
          hz.id_ex_write_en  = 1'b0;
          hz.ex_mem_write_en = 1'b0;
          stall_inc          = 1'b1;
          wait_next = (wait_reg >= WAIT_LIMIT) ? wait_reg : wait_reg + 16'd1;
        end else begin
          do_run = 1'b1;
        end
      end
      default: do_run = 1'b1;
    endcase

    if (do_run) begin
      state_next = RUN;
      wait_next  = 16'd0;
      if (hz.dmem_busy) begin
        hz.pc_write_en     = 1'b0;
        hz.if_id_write_en  = 1'b0;
        hz.id_ex_write_en  = 1'b0;
        hz.ex_mem_write_en = 1'b0;
        stall_inc          = 1'b1;
        state_next         = MEM_WAIT;
        wait_next          = 16'd1;
      end else if (hz.ex_branch_taken) begin
        hz.pc_redirect = 1'b1;
        hz.if_id_flush = 1'b1;
        hz.id_ex_flush = 1'b1;
        flush_inc      = 1'b1;
        if (BUBBLE_LOAD != 4'd0) begin
          state_next  = REDIRECT;
          bubble_next = BUBBLE_LOAD;
        end
      end else if (load_use) begin
        hz.pc_write_en    = 1'b0;
        hz.if_id_write_en = 1'b0;
        hz.id_ex_flush    = 1'b1;
        stall_inc         = 1'b1;
      end
    end

    // Reset forces a safe pipeline immediately, independent of the clock.
    if (reset) begin
      hz.pc_write_en     = 1'b0;
      hz.if_id_write_en  = 1'b0;
      hz.id_ex_write_en  = 1'b0;
      hz.ex_mem_write_en = 1'b0;
      hz.if_id_flush     = 1'b1;
      hz.id_ex_flush     = 1'b1;
      hz.pc_redirect     = 1'b0;
      hz.redirect_target = 32'd0;
    end
  end

  // State, counters and the sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= RUN;
      bubble_reg   <= 4'd0;
      wait_reg     <= 16'd0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state_reg  <= state_next;
      bubble_reg <= bubble_next;
      wait_reg   <= wait_next;
      if (wait_next == WAIT_LIMIT)
        mem_timeout <= 1'b1;
      if (stall_inc && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_inc && (flush_events != '1))
        flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: the stimulus process predicts each cycle's controls from
// the hazard rules and queues them; a monitor compares on every falling edge.
module tb_pipeline_hazard_ctrl;
  localparam int RB = 2;
  localparam int MT = 4;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic          pc_we;
    logic          pc_redir;
    logic [31:0]   target;
    logic          ifid_we;
    logic          ifid_flush;
    logic          idex_we;
    logic          idex_flush;
    logic          exmem_we;
    logic          timeout;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } obs_t;

  typedef struct {
    obs_t  exp;
    string tag;
  } entry_t;

  logic clk = 1'b0;
  logic reset;
  logic mem_timeout;
  logic [CW-1:0] stall_cycles, flush_events;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(
    .REDIRECT_BUBBLES (RB),
    .MEM_TIMEOUT      (MT),
    .CNT_W            (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hz           (hz),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  always #5 clk = ~clk;

  entry_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int txn = 0;

  // Reference model: remaining flushed fetch slots, consecutive busy cycles,
  // and the saturating counters, all as plain integers.
  int m_bub_left = 0;
  int m_busy_run = 0;
  int m_stall = 0;
  int m_flush = 0;
  bit m_to = 1'b0;

  task automatic drive(input string tag, input bit rst, input bit busy, input bit br,
                       input logic [31:0] tgt, input bit mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2);
    entry_t e;
    bit lu;
    reset = rst;
    hz.dmem_busy = busy;
    hz.ex_branch_taken = br;
    hz.ex_branch_target = tgt;
    hz.ex_mem_read = mr;
    hz.ex_rd = rd;
    hz.id_rs1 = rs1;
    hz.id_rs2 = rs2;
    hz.id_uses_rs1 = u1;
    hz.id_uses_rs2 = u2;

    e.tag = tag;
    e.exp = '0;
    e.exp.pc_we = 1'b1;
    e.exp.ifid_we = 1'b1;
    e.exp.idex_we = 1'b1;
    e.exp.exmem_we = 1'b1;
    e.exp.target = tgt;
    e.exp.timeout = m_to;
    e.exp.stall = CW'(m_stall);
    e.exp.flush = CW'(m_flush);

    if (rst) begin
      e.exp = '0;
      e.exp.ifid_flush = 1'b1;
      e.exp.idex_flush = 1'b1;
      m_bub_left = 0;
      m_busy_run = 0;
      m_stall = 0;
      m_flush = 0;
      m_to = 1'b0;
    end else begin
      lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      if (busy) begin
        e.exp.pc_we = 1'b0;
        e.exp.ifid_we = 1'b0;
        e.exp.idex_we = 1'b0;
        e.exp.exmem_we = 1'b0;
        if (m_stall < CNT_MAX) m_stall++;
        if (m_bub_left > 0) begin
          e.exp.ifid_flush = 1'b1;
        end else begin
          m_busy_run++;
          if (m_busy_run >= MT) begin
            m_busy_run = MT;
            m_to = 1'b1;
          end
        end
      end else begin
        m_busy_run = 0;
        if (br) begin
          e.exp.pc_redir = 1'b1;
          e.exp.ifid_flush = 1'b1;
          e.exp.idex_flush = 1'b1;
          if (m_flush < CNT_MAX) m_flush++;
          m_bub_left = RB;
        end else if (m_bub_left > 0) begin
          e.exp.ifid_flush = 1'b1;
          m_bub_left--;
        end else if (lu) begin
          e.exp.pc_we = 1'b0;
          e.exp.ifid_we = 1'b0;
          e.exp.idex_flush = 1'b1;
          if (m_stall < CNT_MAX) m_stall++;
        end
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic cyc(input string tag, input bit rst, input bit busy, input bit br,
                     input logic [31:0] tgt, input bit mr, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input bit u1, input bit u2);
    @(posedge clk);
    #1;
    drive(tag, rst, busy, br, tgt, mr, rd, rs1, rs2, u1, u2);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  task automatic do_reset();
    cyc("reset", 1, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  // Monitor: compare the DUT against the oldest queued prediction.
  always @(negedge clk) begin
    obs_t act;
    entry_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      act = {hz.pc_write_en, hz.pc_redirect, hz.redirect_target, hz.if_id_write_en,
             hz.if_id_flush, hz.id_ex_write_en, hz.id_ex_flush, hz.ex_mem_write_en,
             mem_timeout, stall_cycles, flush_events};
      checks++;
      txn++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s (txn %0d): got %h expected %h", e.tag, txn, act, e.exp);
      end else begin
        $display("txn %0d %s ok: ctrl=%h", txn, e.tag, act);
      end
    end
  end

  initial begin
    reset = 1'b1;
    hz.dmem_busy = 1'b0;
    hz.ex_branch_taken = 1'b0;
    hz.ex_branch_target = 32'h0;
    hz.ex_mem_read = 1'b0;
    hz.ex_rd = 5'd0;
    hz.id_rs1 = 5'd0;
    hz.id_rs2 = 5'd0;
    hz.id_uses_rs1 = 1'b0;
    hz.id_uses_rs2 = 1'b0;

    do_reset();
    do_reset();

    // Load-use on rs2, then the same with a load into x0.
    cyc("lu_hit", 0, 0, 0, 32'h0, 1, 5'd5, 5'd0, 5'd5, 0, 1);
    idle("lu_after");
    cyc("lu_rd0", 0, 0, 0, 32'h0, 1, 5'd0, 5'd0, 5'd0, 0, 1);
    idle("lu_rd0_after");

    // Redirect followed by two fetch bubbles.
    do_reset();
    cyc("br_0x100", 0, 0, 1, 32'h100, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle("bubble1");
    idle("bubble2");
    idle("bubble_done");

    // Freeze beats branch beats load-use; branch serviced on exit.
    do_reset();
    for (int i = 0; i < 3; i++)
      cyc("freeze_all", 0, 1, 1, 32'h200, 1, 5'd3, 5'd3, 5'd0, 1, 0);
    cyc("freeze_exit_br", 0, 0, 1, 32'h200, 1, 5'd3, 5'd3, 5'd0, 1, 0);
    idle("post_freeze1");
    idle("post_freeze2");
    idle("post_freeze3");

    // Timeout: six busy cycles, flag stays set until reset.
    do_reset();
    for (int i = 0; i < 6; i++)
      cyc("busy_timeout", 0, 1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle("timeout_sticky1");
    idle("timeout_sticky2");
    do_reset();
    idle("timeout_cleared");

    // Reset asserted mid-cycle while in the bubble window.
    cyc("br_async", 0, 0, 1, 32'h300, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    @(posedge clk);
    #3;
    drive("async_reset", 1, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle("after_release");
    idle("after_release2");

    // Counter saturation at 4'hF.
    do_reset();
    for (int i = 0; i < 20; i++)
      cyc("lu_sat", 0, 0, 0, 32'h0, 1, 5'd7, 5'd7, 5'd0, 1, 0);
    idle("sat_hold");

    // Randomised segments, each starting from reset.
    for (int s = 0; s < 40; s++) begin
      do_reset();
      for (int c = 0; c < 15; c++) begin
        cyc("rand", 0,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 5 && sb_q.size() > 0; i++)
      @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
